// File: rtl/imm_pkg.sv
// Package imm_pkg: ImmSrc encodings and the immediate decode function shared
// by the decode-stage immediate generator.
// Optional feature macro: IMM_CSR_EN (makes code 101 the zero-extended CSR uimm).
package imm_pkg;

  // Immediate type selects
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  // Widest supported XLEN; narrower users keep the low bits, which is
  // exact because every immediate is sign- or zero-extended from the top.
  localparam int XLEN_MAX = 64;

  // Returns {illegal, imm[XLEN_MAX-1:0]}. Illegal codes yield a zero immediate.
  function automatic logic [XLEN_MAX:0] imm_decode(input logic [31:0] instr,
                                                   input logic [2:0]  src);
    logic [XLEN_MAX-1:0] imm_v;
    logic                illegal_v;
    imm_v     = {XLEN_MAX{1'b0}};
    illegal_v = 1'b0;
    case (src)
      IMM_I: imm_v = {{52{instr[31]}}, instr[31:20]};
      IMM_S: imm_v = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_v = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U: imm_v = {{32{instr[31]}}, instr[31:12], 12'h000};
      IMM_J: imm_v = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
`ifdef IMM_CSR_EN
      IMM_Z: imm_v = {59'd0, instr[19:15]};
`else
      IMM_Z: begin
        imm_v     = {XLEN_MAX{1'b0}};
        illegal_v = 1'b1;
      end
`endif
      default: begin
        imm_v     = {XLEN_MAX{1'b0}};
        illegal_v = 1'b1;
      end
    endcase
    return {illegal_v, imm_v};
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: generic 2-entry valid/ready pipeline register with a skid
// entry. in_ready is a register (never a combinational function of
// out_ready); a beat arriving while the output is stalled parks in the skid
// entry and in_ready drops on the following cycle.
module imm_skid_buf
  import imm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  logic         skid_valid_r;
  logic [W-1:0] skid_data_r;
  logic         in_ready_r;

  logic         out_valid_nxt_s;
  logic [W-1:0] out_data_nxt_s;
  logic         skid_valid_nxt_s;
  logic [W-1:0] skid_data_nxt_s;
  logic         accept_s;
  logic         out_free_s;

  assign accept_s   = in_valid & in_ready_r;
  assign out_free_s = ~out_valid_r | out_ready;

  // Next-state selection for the output and skid entries
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    out_data_nxt_s   = out_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_data_nxt_s  = skid_data_r;
    if (skid_valid_r) begin
      // in_ready is low here, so no new beat competes with the skid entry
      if (out_ready) begin
        out_valid_nxt_s  = 1'b1;
        out_data_nxt_s   = skid_data_r;
        skid_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
      end
    end else if (accept_s) begin
      if (out_free_s) begin
        out_valid_nxt_s = 1'b1;
        out_data_nxt_s  = in_data;
      end else begin
        skid_valid_nxt_s = 1'b1;
        skid_data_nxt_s  = in_data;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State registers; reset drops both entries immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_data_r   <= out_data_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered I/S/B/U/J immediate generator for the decode
// stage, with a valid/ready handshake through a 2-entry skid buffer, an
// illegal-code flag per beat, a sticky error bit and a saturating counter.
// Optional feature macro: IMM_CSR_EN (code 101 becomes the CSR uimm).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int W = 1 + TAG_W + XLEN;

  logic [XLEN_MAX:0] dec_s;
  logic [XLEN-1:0]   imm_s;
  logic              illegal_s;
  logic [W-1:0]      in_data_s;
  logic [W-1:0]      out_data_s;
  logic              accept_s;
  logic              ill_accept_s;
  logic              err_sticky_r;
  logic [CNT_W-1:0]  illegal_cnt_r;

  // Decode the immediate for the beat currently on the input
  always_comb begin
    dec_s = imm_decode(in_instr, in_imm_src);
  end

  assign imm_s     = dec_s[XLEN-1:0];
  assign illegal_s = dec_s[XLEN_MAX];

  // Upper decode bits are redundant sign copies when XLEN is narrower
  generate
    if (XLEN < XLEN_MAX) begin : g_narrow
      logic unused_hi_s;
      assign unused_hi_s = ^dec_s[XLEN_MAX-1:XLEN];
    end
  endgenerate

  assign in_data_s = {illegal_s, in_tag, imm_s};

  imm_skid_buf #(
    .W(W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  assign {out_illegal, out_tag, out_imm} = out_data_s;

  assign accept_s     = in_valid & in_ready;
  assign ill_accept_s = accept_s & illegal_s;

  // Sticky error bit: a new illegal beat takes priority over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_r <= 1'b0;
    end else if (ill_accept_s) begin
      err_sticky_r <= 1'b1;
    end else if (err_clr) begin
      err_sticky_r <= 1'b0;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end

  // Saturating illegal-beat counter; clear with a coincident increment gives 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt_r <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      illegal_cnt_r <= ill_accept_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (ill_accept_s && (illegal_cnt_r != {CNT_W{1'b1}})) begin
      illegal_cnt_r <= illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

  assign err_sticky  = err_sticky_r;
  assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: the driver pushes the expected beat
// when the DUT accepts it, an independent monitor pops and compares.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             err_sticky;
  logic             err_clr;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal),
    .err_sticky(err_sticky), .err_clr(err_clr), .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  logic model_sticky = 1'b0;
  bit   rand_rdy = 1'b0;

  // Reference immediate from field arithmetic on a sign-extended word
  function automatic logic [63:0] ref_imm(input logic [31:0] instr,
                                          input logic [2:0] src,
                                          output logic ill);
    longint s;
    logic [63:0] r;
    s   = $signed(instr);
    ill = 1'b0;
    r   = 64'h0;
    case (src)
      3'd0: r = s >>> 20;
      3'd1: r = ((s >>> 25) << 5) | ((s >> 7) & 64'h1f);
      3'd2: r = ((s >>> 31) << 12) | (((s >> 7) & 64'h1) << 11)
              | (((s >> 25) & 64'h3f) << 5) | (((s >> 8) & 64'hf) << 1);
      3'd3: r = (s >>> 12) << 12;
      3'd4: r = ((s >>> 31) << 20) | (((s >> 12) & 64'hff) << 12)
              | (((s >> 20) & 64'h1) << 11) | (((s >> 21) & 64'h3ff) << 1);
`ifdef IMM_CSR_EN
      3'd5: r = (s >> 15) & 64'h1f;
`else
      3'd5: ill = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one beat until accepted; update the scoreboard and error model
  task automatic send(input logic [31:0] instr, input logic [2:0] src,
                      input logic [TAG_W-1:0] tag, input logic clr);
    logic        ill;
    logic [63:0] r;
    exp_t        e;
    int          waited;
    bit          done;
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    in_tag     = tag;
    err_clr    = clr;
    r      = ref_imm(instr, src, ill);
    done   = 1'b0;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        e.imm = r[XLEN-1:0];
        e.tag = tag;
        e.ill = ill;
        sb_q.push_back(e);
        if (clr) begin
          model_cnt = ill ? 1 : 0;
        end else if (ill && model_cnt != 255) begin
          model_cnt++;
        end
        model_sticky = ill ? 1'b1 : (clr ? 1'b0 : model_sticky);
        done = 1'b1;
      end else begin
        if (clr) begin
          model_cnt    = 0;
          model_sticky = 1'b0;
        end
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: got in_ready=0 required accept within 50 cycles");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has left the DUT
  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compare presented beats against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got imm 0x%0h required no beat", out_imm);
        end else begin
          e = sb_q[0];
          check("out_imm", 64'(out_imm), 64'(e.imm));
          check("out_tag", 64'(out_tag), 64'(e.tag));
          check("out_illegal", 64'(out_illegal), 64'(e.ill));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Random output backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_imm_src = 3'd0;
    in_tag = '0; out_ready = 1'b1; err_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // I type, one-cycle latency
    send(32'hFFF00093, 3'd0, 5'd1, 1'b0);
    check("i_latency_valid", 64'(out_valid), 64'd1);
    check("i_imm", 64'(out_imm), 64'hFFFFFFFF);
    // S then B back-to-back
    send(32'hFE20AE23, 3'd1, 5'd2, 1'b0);
    check("s_imm", 64'(out_imm), 64'hFFFFFFFC);
    send(32'hFE000EE3, 3'd2, 5'd3, 1'b0);
    check("b_valid", 64'(out_valid), 64'd1);
    check("b_imm", 64'(out_imm), 64'hFFFFFFFC);
    // U type
    send(32'h123450B7, 3'd3, 5'd4, 1'b0);
    check("u_imm", 64'(out_imm), 64'h12345000);
    // Illegal code, then illegal with coincident clear, then a plain clear
    send(32'h12345678, 3'd7, 5'd5, 1'b0);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_imm", 64'(out_imm), 64'd0);
    check("ill_tag", 64'(out_tag), 64'd5);
    check("ill_sticky", 64'(err_sticky), 64'd1);
    check("ill_cnt", 64'(illegal_cnt), 64'd1);
    send(32'h0BADF00D, 3'd6, 5'd6, 1'b1);
    check("ill_clr_sticky", 64'(err_sticky), 64'd1);
    check("ill_clr_cnt", 64'(illegal_cnt), 64'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_cnt = 0; model_sticky = 1'b0;
    check("clr_sticky", 64'(err_sticky), 64'd0);
    check("clr_cnt", 64'(illegal_cnt), 64'd0);
    drain();

    // Backpressure: three beats with the consumer stalled
    out_ready = 1'b0;
    send(32'hFFF00093, 3'd0, 5'd11, 1'b0);
    send(32'h123450B7, 3'd3, 5'd12, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    fork
      send(32'hFE20AE23, 3'd1, 5'd13, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_imm", 64'(out_imm), 64'hFFFFFFFF);
          check("bp_hold_tag", 64'(out_tag), 64'd11);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure and occasional clears
    rand_rdy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      send($urandom, 3'($urandom_range(0, 7)), TAG_W'($urandom),
           ($urandom_range(0, 15) == 0));
      check("rnd_sticky", 64'(err_sticky), 64'(model_sticky));
      check("rnd_cnt", 64'(illegal_cnt), 64'(model_cnt));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Reset with both entries full
    out_ready = 1'b0;
    send(32'h00500093, 3'd0, 5'd21, 1'b0);
    send(32'h00A00093, 3'd0, 5'd22, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sticky", 64'(err_sticky), 64'd0);
    sb_q.delete();
    model_cnt = 0; model_sticky = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle", 64'(out_valid), 64'd0);
    send(32'h800000B7, 3'd3, 5'd23, 1'b0);
    check("postrst_valid", 64'(out_valid), 64'd1);
    check("postrst_imm", 64'(out_imm), 64'h80000000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
